// File: rtl/adder_arbiter.sv
// adder_arbiter: two-port valid/ready arbiter that shares one ADDER and returns S plus {V,C,N,Z}.
// Define ADDARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module ADDER #(
  parameter int size = 32
) (
  input  logic            S1,
  input  logic            S0,
  input  logic            C_in,
  input  logic [size-1:0] X,
  input  logic [size-1:0] Y,
  output logic [size-1:0] S,
  output logic            V,
  output logic            C,
  output logic            N,
  output logic            Z
);
  logic            add, sub;
  logic [size:0]   sum;
  assign add = ~S1 & S0;
  assign sub = S1 & ~S0;
  // For subtraction bit [size] is the borrow, so carry-out is its inverse
  assign sum = add ? {1'b0, X} + {1'b0, Y} + {{size{1'b0}}, C_in}
             : sub ? {1'b0, X} - {1'b0, Y}
             : {1'b0, Y};
  assign S = sum[size-1:0];
  assign C = add ? sum[size] : sub ? ~sum[size] : 1'b0;
  assign N = sub & ($signed(X) < $signed(Y));
  assign V = (S[size-1] ^ X[size-1]) & ~(X[size-1] ^ Y[size-1]);
  assign Z = ~|S;
endmodule

module adder_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid_i,
  output logic             req0_ready_o,
  input  logic [WIDTH-1:0] req0_x_i,
  input  logic [WIDTH-1:0] req0_y_i,
  input  logic [1:0]       req0_op_i,
  input  logic             req0_cin_i,
  input  logic             req1_valid_i,
  output logic             req1_ready_o,
  input  logic [WIDTH-1:0] req1_x_i,
  input  logic [WIDTH-1:0] req1_y_i,
  input  logic [1:0]       req1_op_i,
  input  logic             req1_cin_i,
  output logic             rsp0_valid_o,
  input  logic             rsp0_ready_i,
  output logic             rsp1_valid_o,
  input  logic             rsp1_ready_i,
  output logic [WIDTH-1:0] rsp_data_o,
  output logic [3:0]       rsp_flags_o,
  output logic             busy_o
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t           state_q, state_d;
  logic             owner_q, gnt0, gnt1, accept;
  logic [WIDTH-1:0] x_q, y_q, data_q, sum_s;
  logic [1:0]       op_q;
  logic             cin_q, f_v, f_c, f_n, f_z;
  logic [3:0]       flags_q;
`ifdef ADDARB_ROUND_ROBIN_EN
  logic last_q, last_d;
  // last resets to 1 so port 0 wins the first contention
  assign gnt1   = req1_valid_i & (~req0_valid_i | ~last_q);
  assign last_d = accept ? gnt1 : last_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last_q <= 1'b1;
    else last_q <= last_d;
`else
  assign gnt1 = req1_valid_i & ~req0_valid_i;
`endif
  assign gnt0   = req0_valid_i & ~gnt1;
  assign accept = (state_q == IDLE) & (gnt0 | gnt1);
  ADDER #(.size(WIDTH)) u_adder (
    .S1(op_q[1]), .S0(op_q[0]), .C_in(cin_q), .X(x_q), .Y(y_q),
    .S(sum_s), .V(f_v), .C(f_c), .N(f_n), .Z(f_z)
  );
  always_comb begin
    state_d      = state_q;
    req0_ready_o = 1'b0;
    req1_ready_o = 1'b0;
    rsp0_valid_o = 1'b0;
    rsp1_valid_o = 1'b0;
    busy_o       = 1'b0;
    case (state_q)
      IDLE: begin
        req0_ready_o = gnt0;
        req1_ready_o = gnt1;
        state_d      = accept ? EXEC : IDLE;
      end
      EXEC: begin
        busy_o  = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        busy_o       = 1'b1;
        rsp0_valid_o = ~owner_q;
        rsp1_valid_o = owner_q;
        state_d      = (owner_q ? rsp1_ready_i : rsp0_ready_i) ? IDLE : RESP;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      op_q    <= 2'b00;
      cin_q   <= 1'b0;
      data_q  <= '0;
      flags_q <= 4'h0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        owner_q <= gnt1;
        x_q     <= gnt1 ? req1_x_i : req0_x_i;
        y_q     <= gnt1 ? req1_y_i : req0_y_i;
        op_q    <= gnt1 ? req1_op_i : req0_op_i;
        cin_q   <= gnt1 ? req1_cin_i : req0_cin_i;
      end
      if (state_q == EXEC) begin
        data_q  <= sum_s;
        flags_q <= {f_v, f_c, f_n, f_z};
      end
    end
  assign rsp_data_o  = data_q;
  assign rsp_flags_o = flags_q;
endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: scoreboard bench for adder_arbiter; expected grant order follows ADDARB_ROUND_ROBIN_EN.
module tb_adder_arbiter;
  typedef struct {
    int          port;
    logic [31:0] data;
    logic [3:0]  flags;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_ready;
  logic [31:0] req_x [2];
  logic [31:0] req_y [2];
  logic [1:0]  req_op [2];
  logic [1:0]  req_cin = 2'b00;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready = 2'b11;
  logic [31:0] rsp_data;
  logic [3:0]  rsp_flags;
  logic        busy;
  exp_t        sb [$];
  exp_t        e;
  int          n_checks = 0;
  int          n_errors = 0;
  adder_arbiter #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid_i(req_valid[0]), .req0_ready_o(req_ready[0]),
    .req0_x_i(req_x[0]), .req0_y_i(req_y[0]), .req0_op_i(req_op[0]), .req0_cin_i(req_cin[0]),
    .req1_valid_i(req_valid[1]), .req1_ready_o(req_ready[1]),
    .req1_x_i(req_x[1]), .req1_y_i(req_y[1]), .req1_op_i(req_op[1]), .req1_cin_i(req_cin[1]),
    .rsp0_valid_o(rsp_valid[0]), .rsp0_ready_i(rsp_ready[0]),
    .rsp1_valid_o(rsp_valid[1]), .rsp1_ready_i(rsp_ready[1]),
    .rsp_data_o(rsp_data), .rsp_flags_o(rsp_flags), .busy_o(busy)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // Reference: {V,C,N,Z,S}; subtract is X + ~Y + 1 so carry-out means no borrow
  function automatic logic [35:0] model(input logic [1:0] op, input logic [31:0] x, y, input logic cin);
    logic [32:0] t;
    logic [31:0] s;
    logic        c, n, v;
    t = {1'b0, y};
    if (op == 2'b01) t = {1'b0, x} + {1'b0, y} + {32'd0, cin};
    if (op == 2'b10) t = {1'b0, x} + {1'b0, ~y} + 33'd1;
    s = t[31:0];
    c = (op == 2'b01 || op == 2'b10) ? t[32] : 1'b0;
    n = (op == 2'b10) && ($signed(x) < $signed(y));
    v = (s[31] ^ x[31]) & ~(x[31] ^ y[31]);
    return {v, c, n, s == 32'd0, s};
  endfunction
  always @(negedge clk)
    if (rst_n)
      for (int p = 0; p < 2; p++)
        if (rsp_valid[p] && rsp_ready[p]) begin
          if (sb.size() == 0) check("rsp_unexpected", 1, 0);
          else begin
            e = sb.pop_front();
            check("rsp_port", p, e.port);
            check("rsp_data", rsp_data, e.data);
            check("rsp_flags", rsp_flags, e.flags);
          end
        end
  task automatic wait_ready(input int p, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready[p]) begin
        ok = 1'b1;
        return;
      end
      @(posedge clk) #1;
    end
    check("ready_timeout", 0, 1);
  endtask
  task automatic txn(input int p, input logic [1:0] op, input logic [31:0] x, y, input logic cin,
                     input logic [31:0] ed, input logic [3:0] ef);
    bit ok;
    req_x[p] = x; req_y[p] = y; req_op[p] = op; req_cin[p] = cin; req_valid[p] = 1'b1;
    wait_ready(p, ok);
    if (ok) begin
      check("other_ready", req_ready[1-p], 0);
      sb.push_back('{p, ed, ef});
    end
    @(posedge clk) #1 req_valid[p] = 1'b0;
    if (!ok) return;
    @(negedge clk);
    check("exec_busy", busy, 1);
    check("exec_rsp_valid", rsp_valid, 0);
    @(posedge clk) #1;
    @(negedge clk);
    check("resp_valid", rsp_valid, 2'b01 << p);
    @(posedge clk) #1;
    @(negedge clk);
    check("idle_busy", busy, 0);
    @(posedge clk) #1;
  endtask
  task automatic check_reset_outputs();
    check("rst_busy", busy, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_data", rsp_data, 0);
    check("rst_flags", rsp_flags, 0);
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    check_reset_outputs();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk) #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bit          ok;
    int          g;
    logic [35:0] m;
    logic [1:0]  op;
    logic [31:0] x, y;
    logic        cin;
    for (int i = 0; i < 2; i++) begin
      req_x[i] = '0; req_y[i] = '0; req_op[i] = '0;
    end
    do_reset();
    txn(0, 2'b01, 32'hFFFF_FFFF, 32'h1, 1'b0, 32'h0, 4'b0101);
    txn(1, 2'b10, 32'd5, 32'd7, 1'b0, 32'hFFFF_FFFE, 4'b1010);
    txn(0, 2'b01, 32'h7FFF_FFFF, 32'h1, 1'b0, 32'h8000_0000, 4'b1000);
    txn(0, 2'b00, 32'h1234_5678, 32'h0, 1'b0, 32'h0, 4'b0001);
    txn(1, 2'b11, 32'h0, 32'hCAFE_0001, 1'b1, 32'hCAFE_0001, 4'b0000);
    txn(0, 2'b01, 32'h1, 32'h2, 1'b1, 32'h4, 4'b0000);
    for (int i = 0; i < 8; i++) begin
      g = int'($urandom_range(1, 0));
      op = 2'($urandom);
      x = $urandom;
      y = (i == 3) ? x : $urandom;
      cin = 1'($urandom);
      m = model(op, x, y, cin);
      txn(g, op, x, y, cin, m[31:0], m[35:32]);
    end
    // Both ports contend continuously straight out of reset
    do_reset();
    req_x[0] = 32'h100; req_y[0] = 32'h1; req_op[0] = 2'b01; req_cin[0] = 1'b0;
    req_x[1] = 32'h200; req_y[1] = 32'h2; req_op[1] = 2'b01; req_cin[1] = 1'b0;
    req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      ok = 1'b0;
      for (int k = 0; k < 20 && !ok; k++) begin
        @(negedge clk);
        if (|req_ready) ok = 1'b1;
        else @(posedge clk) #1;
      end
      if (!ok) check("contend_timeout", 0, 1);
      else begin
        g = req_ready[1] ? 1 : 0;
`ifdef ADDARB_ROUND_ROBIN_EN
        check("grant_order", g, i % 2);
`else
        check("grant_order", g, 0);
`endif
        check("grant_onehot", req_ready, 2'b01 << g);
        m = model(2'b01, req_x[g], req_y[g], 1'b0);
        sb.push_back('{g, m[31:0], m[35:32]});
      end
      @(posedge clk) #1;
    end
    req_valid = 2'b00;
    repeat (3) @(posedge clk) #1;
    // Owner stalls its response while the other port waits
    rsp_ready[1] = 1'b0;
    req_x[1] = 32'h10; req_y[1] = 32'h20; req_op[1] = 2'b01; req_cin[1] = 1'b0;
    req_valid[1] = 1'b1;
    wait_ready(1, ok);
    if (ok) sb.push_back('{1, 32'h30, 4'b0000});
    @(posedge clk) #1;
    req_valid[1] = 1'b0;
    req_x[0] = 32'd9; req_y[0] = 32'd3; req_op[0] = 2'b10; req_cin[0] = 1'b0;
    req_valid[0] = 1'b1;
    @(posedge clk) #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_valid", rsp_valid, 2'b10);
      check("hold_data", rsp_data, 32'h30);
      check("hold_flags", rsp_flags, 4'b0000);
      check("hold_other_ready", req_ready, 0);
      check("hold_busy", busy, 1);
      @(posedge clk) #1;
    end
    rsp_ready[1] = 1'b1;
    wait_ready(0, ok);
    if (ok) sb.push_back('{0, 32'd6, 4'b0100});
    @(posedge clk) #1;
    req_valid[0] = 1'b0;
    repeat (3) @(posedge clk) #1;
    // Reset lands mid-EXEC; the in-flight add must vanish
    req_x[0] = 32'h1; req_y[0] = 32'h2; req_op[0] = 2'b01; req_cin[0] = 1'b0;
    req_valid[0] = 1'b1;
    wait_ready(0, ok);
    @(posedge clk) #1;
    req_valid[0] = 1'b0;
    check("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_no_rsp", rsp_valid, 0);
    end
    @(posedge clk) #1;
    txn(1, 2'b10, 32'h8000_0000, 32'h1, 1'b0, 32'h7FFF_FFFF, 4'b0110);
    check("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/adder_arbiter.md
# adder_arbiter

- Shares one `ADDER` instance (size = WIDTH) between two requesters, e.g. the PC-increment path and the ALU/address-generation path of the RV32I core.
- Arbitrates on a valid/ready handshake, registers the winner's operands and drives the shared adder's S1/S0/C_in.
- Captures S and the V/C/N/Z flags into a result register and returns them over a per-port response handshake.

## Interface
- WIDTH, 32, operand/result width; passed to the internal `ADDER` size.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- reqN_valid  in  1  (N = 0,1) request valid.
- reqN_ready  out  1  request accepted this cycle.
- reqN_x  in  WIDTH  operand X.
- reqN_y  in  WIDTH  operand Y.
- reqN_op  in  2  adder select {S1,S0}:
  - 00 pass Y
  - 01 X+Y+cin
  - 10 X−Y
  - 11 pass Y
- reqN_cin  in  1  carry-in, used for op 01 only.
- rspN_valid  out  1  result for port N available.
- rspN_ready  in  1  port N consumes result.
- rsp_data  out  WIDTH  registered result S, shared by both ports.
- rsp_flags  out  4  registered {V,C,N,Z} from the adder.
- busy  out  1  high in EXEC and RESP.

## Operation
- States:
  - IDLE: no transaction.
  - EXEC: operands registered, adder evaluating.
  - RESP: result held for the owner port.
- IDLE:
  - If any reqN_valid is high, the grant goes to the selected port, and only that port's reqN_ready is high (combinational).
  - At the clock edge, x, y, op, cin and the owner id are latched, and the state moves to EXEC.
  - If no request is valid, the state stays in IDLE.
- EXEC:
  - The adder is driven from the registered operands only.
  - At the clock edge, S and the flags are latched into rsp_data/rsp_flags, and the state moves to RESP.
- RESP:
  - rspN_valid is high for the owner port only, and stays high until that port's rspN_ready is sampled high.
  - On that edge the state moves to IDLE. rspN_ready from the non-owner port is ignored.
- Arbitration: a `last` pointer records the most recently granted port.
  - When both ports are valid, the grant goes to the port that is not `last`.
  - When only one port is valid, that port is granted.
  - `last` updates only on an accept edge.
- reqN_ready is 0 outside IDLE. Requesters must hold valid and operands stable until ready is seen.
- Flags are exactly the adder's outputs:
  - Z = result is zero.
  - C = carry out for ops 01/10, 0 otherwise.
  - N = signed X<Y for op 10, 0 otherwise.
  - V = (S[msb]^X[msb]) & ~(X[msb]^Y[msb]), for every op.
- Op 11 is legal and behaves identically to 00.

## Timing
- Reset values:
  - state = IDLE
  - last = 1, so port 0 wins the first contention
  - rsp_data = 0, rsp_flags = 0
  - rsp0_valid = rsp1_valid = 0, req0_ready = req1_ready = 0 (when no request is pending), busy = 0
- Latency:
  - Accept edge at end of cycle 0, EXEC in cycle 1, rspN_valid high from cycle 2.
  - With rspN_ready high in cycle 2, IDLE is in cycle 3 and the next accept can happen in cycle 3.
  - Peak throughput is 1 op per 3 cycles.
- rsp_data/rsp_flags are stable for the whole RESP interval, and retain their value in IDLE until the next EXEC capture.
- A request arriving while busy waits; nothing is queued inside the block.
- When both ports become valid in the same cycle while IDLE, exactly one is granted. The other is granted at the next IDLE, provided it is still valid.
- rst_n asserted mid-EXEC or mid-RESP: everything clears immediately, the in-flight transaction is dropped and no response is issued.
- After rst_n deasserts, first accept is on the first edge.

## Configuration
- ADDARB_ROUND_ROBIN_EN defined: round-robin arbitration using `last`, as described above.
- ADDARB_ROUND_ROBIN_EN undefined: fixed priority; port 0 always wins contention, and `last` is not implemented.
- All other behaviour is identical in both builds.

## Test plan
- Port 0 add, x=0xFFFFFFFF, y=0x00000001, cin=0 -> rsp0_valid in cycle 2, rsp_data=0x00000000, flags C=1, Z=1, N=0.
- Port 1 sub, x=5, y=7 -> rsp_data=0xFFFFFFFE, N=1, C=0, Z=0; rsp0_valid stays 0 throughout.
- Port 0 add, x=0x7FFFFFFF, y=1, cin=0 -> rsp_data=0x80000000, V=1. Port 0 op 00, y=0 -> rsp_data=0, Z=1, C=0.
- Both ports held valid for 4 transactions after reset:
  - round-robin build -> grant order 0,1,0,1
  - fixed-priority build -> 0,0,0,0
- rspN_ready held low for 5 cycles -> rspN_valid and rsp_data stay constant, the other port's ready stays 0, and busy=1 throughout.
- rst_n pulsed low during EXEC of an add -> all outputs go to reset values asynchronously, no rsp_valid follows, and the next request completes normally.
